swsw_symbol_feeder: RTL and testbench

Producer end of the swsw monitor symbol bus. Converts per-cycle commit events from the core into the 8-bit symbol stream, `run` strobe and automata reset consumed by the swsw automata stage chain. A small FIFO absorbs bursts; the feeder counts dropped events and frames each monitoring window with an automata reset pulse and an end-of-stream symbol.

---
 rtl/swsw_feeder_pkg.sv | 30 +++
 rtl/swsw_sym_fifo.sv | 55 +++++
 rtl/swsw_symbol_feeder.sv | 135 +++++++++++++
 tb/tb_swsw_symbol_feeder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/swsw_feeder_pkg.sv
// swsw_feeder_pkg: shared types and constants for the swsw symbol feeder.
// Symbol layout: {1'b0, op[1:0], tag[3:0], priv}; MSB=1 is reserved for control symbols.
package swsw_feeder_pkg;

  // Window state of the feeder
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EOS   = 2'd3
  } feeder_state_t;

  // Control symbols (MSB set)
  localparam logic [7:0] SYM_EOS  = 8'h80;
  localparam logic [7:0] SYM_IDLE = 8'h81;

  // Commit op classes
  localparam logic [1:0] OP_OTHER       = 2'b00;
  localparam logic [1:0] OP_LOAD        = 2'b01;
  localparam logic [1:0] OP_STORE_WORD  = 2'b10;
  localparam logic [1:0] OP_STORE_OTHER = 2'b11;

  // Pack one commit event into a data symbol (MSB always clear)
  function automatic logic [7:0] encode_sym(input logic [1:0] op,
                                            input logic [3:0] tag,
                                            input logic       priv);
    return {1'b0, op, tag, priv};
  endfunction

endpackage

// File: rtl/swsw_sym_fifo.sv
// swsw_sym_fifo: DEPTH x WIDTH FIFO with wrap-bit pointers.
// The head entry is read combinationally so the feeder can pop it straight into
// its registered output; a registered read would add a cycle of latency.
// Push and pop in the same cycle are legal even when full.
module swsw_sym_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign dout_o = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset because empty pointers mask them
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din_i;
    end
  end

  // Pointer update; the extra MSB is the wrap bit that separates full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/swsw_symbol_feeder.sv
// swsw_symbol_feeder: turns core commit events into the swsw monitor symbol stream.
// Each window runs INIT (automata reset) -> RUN -> DRAIN (after flush) -> EOS.
// Optional build macro SWSW_FEEDER_IDLE_EN: emit SYM_IDLE with run_o=1 on empty RUN
// cycles so the automata advance every cycle; otherwise run_o stays low and they stall.
module swsw_symbol_feeder
  import swsw_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             evt_valid_i,
  input  logic [1:0]       evt_op_i,
  input  logic [3:0]       evt_tag_i,
  input  logic             evt_priv_i,
  input  logic             flush_i,
  output logic [7:0]       symbols_o,
  output logic             run_o,
  output logic             am_reset_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  feeder_state_t    state_reg, state_next;
  logic [7:0]       sym_reg, sym_next;
  logic             run_reg, run_next;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic [7:0] evt_sym;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       push;
  logic       drop;
  logic       accept_state;

  assign evt_sym = encode_sym(evt_op_i, evt_tag_i, evt_priv_i);

  swsw_sym_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (evt_sym),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Events are only accepted while a window is open; anything refused is a drop
  assign accept_state = (state_reg == ST_INIT) || (state_reg == ST_RUN);
  assign push         = evt_valid_i && accept_state && (!fifo_full || pop);
  assign drop         = evt_valid_i && !push;

  // Next-state, pop and next-output decode; outputs default to hold symbol, run low
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    sym_next   = sym_reg;
    run_next   = 1'b0;
    case (state_reg)
      ST_INIT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          sym_next = fifo_dout;
          run_next = 1'b1;
        end else begin
`ifdef SWSW_FEEDER_IDLE_EN
          sym_next = SYM_IDLE;
          run_next = 1'b1;
`else
          sym_next = sym_reg;
          run_next = 1'b0;
`endif
        end
        if (flush_i) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          sym_next = fifo_dout;
          run_next = 1'b1;
        end else begin
          // EOS symbol is registered on the way in, so it is visible during ST_EOS
          sym_next   = SYM_EOS;
          run_next   = 1'b1;
          state_next = ST_EOS;
        end
      end
      ST_EOS: begin
        state_next = ST_INIT;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // State and registered symbol outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_INIT;
      sym_reg   <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sym_reg   <= sym_next;
      run_reg   <= run_next;
    end
  end

  // Saturating drop counter, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != {CNT_W{1'b1}})) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign symbols_o  = sym_reg;
  assign run_o      = run_reg;
  assign drop_cnt_o = drop_cnt_reg;
  assign am_reset_o = (state_reg == ST_INIT);
  assign busy_o     = !fifo_empty || (state_reg != ST_RUN);

endmodule

// File: tb/tb_swsw_symbol_feeder.sv
// tb_swsw_symbol_feeder: random and directed stimulus against a queue-based
// reference model of the feeder's windowing rules. One line per failed compare.
module tb_swsw_symbol_feeder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  localparam int PH_INIT  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_EOS   = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             evt_valid_i = 1'b0;
  logic [1:0]       evt_op_i = '0;
  logic [3:0]       evt_tag_i = '0;
  logic             evt_priv_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [7:0]       symbols_o;
  logic             run_o;
  logic             am_reset_o;
  logic             busy_o;
  logic [CNT_W-1:0] drop_cnt_o;

  swsw_symbol_feeder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .evt_valid_i (evt_valid_i),
    .evt_op_i    (evt_op_i),
    .evt_tag_i   (evt_tag_i),
    .evt_priv_i  (evt_priv_i),
    .flush_i     (flush_i),
    .symbols_o   (symbols_o),
    .run_o       (run_o),
    .am_reset_o  (am_reset_o),
    .busy_o      (busy_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: window phase, queue of pending symbols, unbounded drop tally
  int m_phase;
  int q[$];
  int m_sym;
  bit m_run;
  int m_drops;

  task automatic model_reset();
    m_phase = PH_INIT;
    q.delete();
    m_sym   = 0;
    m_run   = 1'b0;
    m_drops = 0;
  endtask

  task automatic offer(input bit v, input int sym);
    if (v) begin
      if (q.size() < DEPTH) q.push_back(sym);
      else m_drops++;
    end
  endtask

  // Advance the model over one clock edge given this cycle's inputs
  task automatic model_step(input bit v, input int sym, input bit fl);
    m_run = 1'b0;
    case (m_phase)
      PH_INIT: begin
        offer(v, sym);
        m_phase = PH_RUN;
      end
      PH_RUN: begin
        if (q.size() > 0) begin
          m_sym = q.pop_front();
          m_run = 1'b1;
        end else begin
`ifdef SWSW_FEEDER_IDLE_EN
          m_sym = 'h81;
          m_run = 1'b1;
`endif
        end
        offer(v, sym);
        if (fl) m_phase = PH_DRAIN;
      end
      PH_DRAIN: begin
        if (v) m_drops++;
        if (q.size() > 0) begin
          m_sym = q.pop_front();
          m_run = 1'b1;
        end else begin
          m_sym   = 'h80;
          m_run   = 1'b1;
          m_phase = PH_EOS;
        end
      end
      default: begin
        if (v) m_drops++;
        m_phase = PH_INIT;
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("symbols_o", symbols_o, m_sym);
    check_eq("run_o", run_o, m_run);
    check_eq("am_reset_o", am_reset_o, m_phase == PH_INIT);
    check_eq("busy_o", busy_o, (q.size() != 0) || (m_phase != PH_RUN));
    check_eq("drop_cnt_o", drop_cnt_o, (m_drops > SAT) ? SAT : m_drops);
  endtask

  // Drive one cycle of inputs from a negedge, then compare at the following negedge
  task automatic cycle(input bit v, input logic [1:0] op, input logic [3:0] tag,
                       input bit priv, input bit fl);
    evt_valid_i = v;
    evt_op_i    = op;
    evt_tag_i   = tag;
    evt_priv_i  = priv;
    flush_i     = fl;
    model_step(v, int'(op) * 32 + int'(tag) * 2 + int'(priv), fl);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic rand_cycle(input int pv, input int pf);
    bit v;
    bit fl;
    v  = ($urandom_range(0, 99) < pv);
    fl = ($urandom_range(0, 99) < pf);
    cycle(v, 2'($urandom), 4'($urandom), 1'($urandom), fl);
  endtask

  initial begin
    bit found;
    // Reset state
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    model_reset();
    check_eq("rst_symbols", symbols_o, 8'h00);
    check_eq("rst_run", run_o, 1'b0);
    check_eq("rst_am_reset", am_reset_o, 1'b1);
    check_eq("rst_busy", busy_o, 1'b1);
    check_eq("rst_drop_cnt", drop_cnt_o, 0);
    rst_ni = 1'b1;

    // INIT cycle, then op=10 tag=5 priv=1 in RUN -> 8'h4B two cycles later
    cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    check_eq("am_reset_after_init", am_reset_o, 1'b0);
    cycle(1'b1, 2'b10, 4'd5, 1'b1, 1'b0);
    cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    check_eq("first_sym_4b", symbols_o, 8'h4B);
    check_eq("first_sym_run", run_o, 1'b1);

    // Back-to-back burst while the output pops: no drops
    for (int i = 0; i < 12; i++) rand_cycle(100, 0);
    repeat (4) cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    check_eq("burst_no_drop", drop_cnt_o, 0);

    // Empty FIFO in RUN
`ifdef SWSW_FEEDER_IDLE_EN
    check_eq("idle_sym", symbols_o, 8'h81);
    check_eq("idle_run", run_o, 1'b1);
`else
    check_eq("idle_run", run_o, 1'b0);
`endif

    // Flush with traffic continuing: EOS then automata reset, drops during DRAIN/EOS
    for (int i = 0; i < 3; i++) rand_cycle(100, 0);
    cycle(1'b1, 2'b01, 4'd3, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      rand_cycle(100, 0);
      if (symbols_o == 8'h80 && run_o == 1'b1) found = 1'b1;
    end
    check_eq("eos_seen", found, 1'b1);
    rand_cycle(100, 0);
    check_eq("am_reset_after_eos", am_reset_o, 1'b1);
    check_eq("drain_drops_nonzero", drop_cnt_o != 0, 1'b1);

    // Saturation: constant traffic with frequent flushes
    repeat (800) rand_cycle(100, 50);
    check_eq("drop_saturated", drop_cnt_o, SAT);

    // Reset asserted mid-DRAIN
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      rand_cycle(100, 0);
      if (m_phase == PH_RUN) found = 1'b1;
    end
    check_eq("reach_run", found, 1'b1);
    cycle(1'b1, 2'b11, 4'd9, 1'b1, 1'b1);
    check_eq("in_drain_busy", busy_o, 1'b1);
    evt_valid_i = 1'b0;
    flush_i     = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_symbols", symbols_o, 8'h00);
    check_eq("mid_rst_run", run_o, 1'b0);
    check_eq("mid_rst_am_reset", am_reset_o, 1'b1);
    check_eq("mid_rst_busy", busy_o, 1'b1);
    check_eq("mid_rst_drop_cnt", drop_cnt_o, 0);
    @(negedge clk_i);
    check_eq("mid_rst_no_eos", run_o, 1'b0);
    rst_ni = 1'b1;

    // Mixed random traffic
    repeat (2000) rand_cycle(60, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
